// File: rtl/dm_wr_scheduler_pkg.sv
// Shared types and helpers for the datamover write scheduler.
package dm_wr_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int XFER_CNT_W = 32;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned next_rr(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/dm_wr_scheduler_if.sv
// Requester-side and datamover-side signals of the write scheduler.
interface dm_wr_scheduler_if #(
  parameter int NUM_REQ       = 4,
  parameter int AXI_ADDRWIDTH = 36,
  parameter int DATAWIDTH     = 1024
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*AXI_ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0]     req_data;
  logic [NUM_REQ-1:0]               resp_valid;
  logic [AXI_ADDRWIDTH-1:0]         dm_addr;
  logic [DATAWIDTH-1:0]             dm_wrdata;
  logic                             dm_en;
  logic                             dm_we;
  logic                             dm_done;

  // Requesters plus datamover, seen from outside the scheduler.
  modport master (
    output req_valid, req_addr, req_data, dm_done,
    input  req_ready, resp_valid, dm_addr, dm_wrdata, dm_en, dm_we
  );

  modport slave (
    input  req_valid, req_addr, req_data, dm_done,
    output req_ready, resp_valid, dm_addr, dm_wrdata, dm_en, dm_we
  );
endinterface

// File: rtl/dm_wr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int W = $clog2(N);

  logic [W:0] pos;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves one unassigned would infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (W+1)'(k);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (req_i[pos[W-1:0]]) begin
        grant_o             = '0;
        grant_o[pos[W-1:0]] = 1'b1;
        idx_o               = pos[W-1:0];
        any_o               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_wr_scheduler.sv
// Shares one bram2axi_datamover write engine between NUM_REQ requesters, one transfer at a time.
// The enclosing level resets the datamover with rst_n = ~rst so both restart together.
module dm_wr_scheduler
  import dm_wr_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDRWIDTH  = 36,
  parameter int DATAWIDTH      = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  dm_wr_scheduler_if.slave           bus,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       timeout_o,
  output logic                       err_o,
  input  logic                       err_clr,
  output logic [XFER_CNT_W-1:0]      xfer_cnt_o
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [AXI_ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]     data_q, data_d;
  logic [WDOG_W-1:0]        wdog_q, wdog_d;
  logic                     err_q, err_d;
  logic [XFER_CNT_W-1:0]    cnt_q, cnt_d;
  logic                     timeout;

  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    addr_d         = addr_q;
    data_d         = data_q;
    wdog_d         = wdog_q;
    cnt_d          = cnt_q;
    timeout        = 1'b0;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.dm_en      = 1'b0;
    bus.dm_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          bus.req_ready = grant;
          owner_d       = grant_idx;
          addr_d        = bus.req_addr[grant_idx*AXI_ADDRWIDTH +: AXI_ADDRWIDTH];
          data_d        = bus.req_data[grant_idx*DATAWIDTH +: DATAWIDTH];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        bus.dm_en = 1'b1;
        bus.dm_we = 1'b1;
        wdog_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // Watchdog saturates one past the trip value so the pulse fires once.
        if (wdog_q != WDOG_W'(TIMEOUT_CYCLES)) wdog_d = wdog_q + WDOG_W'(1);
        timeout = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
        if (bus.dm_done) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid[owner_q] = 1'b1;
        cnt_d   = cnt_q + XFER_CNT_W'(1);
        rr_d    = IDX_W'(next_rr(32'(owner_q), NUM_REQ));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dm_addr   = addr_q;
  assign bus.dm_wrdata = data_q;
  assign busy_o        = (state_q != IDLE);
  assign owner_o       = owner_q;
  assign timeout_o     = timeout;
  assign err_o         = err_q;
  assign xfer_cnt_o    = cnt_q;

endmodule

// File: tb/tb_dm_wr_scheduler.sv
// Bench for dm_wr_scheduler: directed scenarios plus random traffic against a transaction-timeline model.
module tb_dm_wr_scheduler;
  localparam int N  = 4;
  localparam int AW = 36;
  localparam int DW = 64;
  localparam int T  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        busy_o;
  logic [1:0]  owner_o;
  logic        timeout_o;
  logic        err_o;
  logic [31:0] xfer_cnt_o;

  dm_wr_scheduler_if #(.NUM_REQ(N), .AXI_ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

  dm_wr_scheduler #(
    .NUM_REQ(N), .AXI_ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy_o),
    .owner_o    (owner_o),
    .timeout_o  (timeout_o),
    .err_o      (err_o),
    .err_clr    (err_clr),
    .xfer_cnt_o (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Model: a transfer is described by its grant cycle and the cycle dm_done was seen in WAIT.
  int          cyc = 0;
  int          m_g = -1;
  int          m_d = -1;
  int          m_owner, m_ptr, pick;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [31:0] m_cnt;
  logic        m_err;
  logic        e_active, e_en, e_wait, e_resp, e_to;
  logic [N-1:0] e_ready, e_resp_v;

  always @(negedge clk) begin
    if (rst) begin
      m_g = -1; m_d = -1; m_owner = 0; m_ptr = 0;
      m_addr = '0; m_data = '0; m_cnt = '0; m_err = 1'b0;
    end
    e_active = (m_g >= 0);
    e_en     = e_active && (cyc == m_g + 1);
    e_wait   = e_active && (cyc >= m_g + 2) && (m_d < 0);
    e_resp   = e_active && (m_d >= 0) && (cyc == m_d + 1);
    e_to     = e_wait && (cyc - m_g - 2 == T - 1);
    pick     = e_active ? -1 : rr_pick(bus.req_valid, m_ptr);
    e_ready  = (pick >= 0) ? N'(1 << pick) : '0;
    e_resp_v = e_resp ? N'(1 << m_owner) : '0;

    check("m_req_ready",  bus.req_ready,  e_ready);
    check("m_resp_valid", bus.resp_valid, e_resp_v);
    check("m_dm_en",      bus.dm_en,      e_en);
    check("m_dm_we",      bus.dm_we,      e_en);
    check("m_dm_addr",    bus.dm_addr,    m_addr);
    check("m_dm_wrdata",  bus.dm_wrdata,  m_data);
    check("m_busy",       busy_o,         e_active);
    check("m_owner",      owner_o,        m_owner);
    check("m_timeout",    timeout_o,      e_to);
    check("m_err",        err_o,          m_err);
    check("m_xfer_cnt",   xfer_cnt_o,     m_cnt);

    if (!rst) begin
      if (pick >= 0) begin
        m_g     = cyc;
        m_owner = pick;
        m_addr  = bus.req_addr[pick*AW +: AW];
        m_data  = bus.req_data[pick*DW +: DW];
      end
      if (e_wait && bus.dm_done) m_d = cyc;
      if (e_to) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (e_resp) begin
        m_cnt   = m_cnt + 1;
        m_ptr   = (m_owner + 1) % N;
        m_g     = -1;
        m_d     = -1;
      end
    end
    cyc++;
  end

  // Called at the start of a handshake cycle with requests already driven.
  task automatic serve(input int exp, input int lat, input bit drop);
    mid();
    check($sformatf("serve_ready_%0d", exp), bus.req_ready, 64'd1 << exp);
    tick();
    if (drop) bus.req_valid = '0;
    repeat (lat) tick();
    bus.dm_done = 1'b1;
    tick();
    bus.dm_done = 1'b0;
    mid();
    check($sformatf("serve_resp_%0d", exp), bus.resp_valid, 64'd1 << exp);
    tick();
  endtask

  logic [N-1:0] pend, hs;
  logic [31:0]  r;

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.dm_done = 1'b0;
    repeat (3) tick();
    mid();
    check("rst_busy", busy_o, 0);
    check("rst_cnt",  xfer_cnt_o, 0);
    check("rst_addr", bus.dm_addr, 0);
    check("rst_err",  err_o, 0);
    tick();
    rst = 1'b0;

    // Single request from requester 2
    tick();
    bus.req_valid = 4'b0100;
    bus.req_addr[2*AW +: AW] = 36'h1_0000_0040;
    bus.req_data[2*DW +: DW] = 64'hA5A5_0000_1234_5678;
    mid();
    check("t1_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    mid();
    check("t1_dm_en",   bus.dm_en, 1);
    check("t1_dm_we",   bus.dm_we, 1);
    check("t1_dm_addr", bus.dm_addr, 36'h1_0000_0040);
    repeat (8) tick();
    bus.dm_done = 1'b1;
    tick();
    bus.dm_done = 1'b0;
    mid();
    check("t1_resp", bus.resp_valid, 4'b0100);
    tick();
    mid();
    check("t1_cnt", xfer_cnt_o, 1);
    tick();

    // All four requesting from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) serve(i % N, 2 + i, 1'b0);

    // Wrap-around: pointer 2 with only 0 and 1 requesting
    bus.req_valid = 4'b0010;
    serve(1, 3, 1'b0);
    bus.req_valid = 4'b0011;
    serve(0, 2, 1'b0);
    serve(1, 2, 1'b1);

    // Watchdog with dm_done withheld
    bus.req_valid = 4'b0001;
    mid();
    check("t4_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    for (int k = 1; k < T; k++) begin
      mid();
      check("t4_no_timeout", timeout_o, 0);
      tick();
    end
    mid();
    check("t4_timeout", timeout_o, 1);
    check("t4_busy",    busy_o, 1);
    tick();
    mid();
    check("t4_pulse_end", timeout_o, 0);
    check("t4_err",       err_o, 1);
    repeat (3) tick();
    bus.dm_done = 1'b1;
    tick();
    bus.dm_done = 1'b0;
    mid();
    check("t4_resp", bus.resp_valid, 4'b0001);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    mid();
    check("t4_err_clr", err_o, 0);
    tick();

    // Reset in the middle of WAIT
    bus.req_valid = 4'b0100;
    mid();
    check("t5_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("t5_busy",  busy_o, 0);
    check("t5_addr",  bus.dm_addr, 0);
    check("t5_cnt",   xfer_cnt_o, 0);
    check("t5_owner", owner_o, 0);
    mid();
    check("t5_no_resp", bus.resp_valid, 0);
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1000;
    serve(3, 4, 1'b1);

    // Stray dm_done in IDLE, then data held after the requester moves on
    bus.dm_done = 1'b1;
    tick();
    bus.dm_done = 1'b0;
    mid();
    check("t6_stray_busy", busy_o, 0);
    check("t6_stray_cnt",  xfer_cnt_o, 1);
    tick();
    bus.req_valid = 4'b0010;
    bus.req_data[1*DW +: DW] = 64'h0123_4567_89AB_CDEF;
    mid();
    check("t6_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    bus.req_data[1*DW +: DW] = 64'hFEDC_BA98_7654_3210;
    for (int k = 0; k < 5; k++) begin
      mid();
      check("t6_wrdata_hold", bus.dm_wrdata, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    bus.dm_done = 1'b1;
    tick();
    bus.dm_done = 1'b0;
    mid();
    check("t6_resp",   bus.resp_valid, 4'b0010);
    check("t6_wrdata", bus.dm_wrdata, 64'h0123_4567_89AB_CDEF);
    tick();

    // Random traffic
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        pend = '0;
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          r = $urandom();
          bus.req_addr[i*AW +: AW] = {r[3:0], $urandom()};
          bus.req_data[i*DW +: DW] = {$urandom(), $urandom()};
        end else if (pend[i] && $urandom_range(0, 31) == 0) begin
          pend[i] = 1'b0;
        end
      end
      bus.req_valid = pend;
      bus.dm_done   = ($urandom_range(0, 5) == 0);
      err_clr       = ($urandom_range(0, 39) == 0);
      mid();
      hs = bus.req_ready;
      tick();
      pend = pend & ~hs;
      for (int i = 0; i < N; i++)
        if (hs[i]) bus.req_data[i*DW +: DW] = {$urandom(), $urandom()};
    end

    bus.req_valid = '0;
    bus.dm_done   = 1'b0;
    err_clr       = 1'b0;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
